font_reader: RTL and testbench
==============================

FONT_READER -- requirements
Module: font_reader

Interface
REQ-001 Parameter X0, default 10'd288, left pixel column of the text window.
REQ-002 Parameter Y0, default 10'd232, top pixel row of the text window.
REQ-003 clk  input  1  the only clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 pixel_tick  input  1  one-clk-wide pixel enable strobe.
REQ-006 video_on  input  1  high inside the visible area.
REQ-007 pixel_x  input  10  current pixel column.
REQ-008 pixel_y  input  10  current pixel row.
REQ-009 wr_en  input  1  message write request.
REQ-010 wr_idx  input  3  message slot 0..7.
REQ-011 wr_code  input  3  glyph code (0 space, 1 J, 2 V, 3 M, 4 B, 5 S, 6 L, 7 blank).
REQ-012 wr_ack  output  1  one-clk pulse confirming a write.
REQ-013 direccion  output  3  glyph-select address to the glyph ROM.
REQ-014 rom  output  4  row-within-glyph address to the glyph ROM.
REQ-015 rom_data  input  8  glyph row from the ROM, combinational on direccion/rom, bit 7 = leftmost pixel.
REQ-016 text_pixel  output  1  registered pixel-on result.

Function
REQ-017 The block SHALL hold an 8-entry x 3-bit message register, msg[0..7].
REQ-018 Write handling: when wr_en=1 at a clk edge, msg[wr_idx] SHALL take wr_code and wr_ack SHALL be 1 for the next clk cycle. wr_ack SHALL be 0 otherwise.
REQ-019 Back-to-back writes on consecutive cycles SHALL all be accepted, one ack per write.
REQ-020 Window: dx=pixel_x-X0, dy=pixel_y-Y0. in_win=1 iff 0<=dx<64 and 0<=dy<16. The compare SHALL be unsigned, so pixels left of or above the window fall outside it and do not wrap into it.
REQ-021 Stage 1, on each clk edge with pixel_tick=1:
  - direccion <= msg[dx[5:3]]
  - rom <= dy[3:0]
  - bit_q <= dx[2:0]
  - win_q <= in_win & video_on
REQ-022 Stage 2, on the next clk edge with pixel_tick=1: text_pixel <= win_q & rom_data[7-bit_q].
REQ-023 Total latency from pixel_x/pixel_y to text_pixel SHALL be exactly 2 pixel_ticks. The consumer delays its syncs by 2 ticks.
REQ-024 With pixel_tick=0, all stage registers SHALL hold their values.
REQ-025 When a write hits the slot being read on the same edge, stage 1 SHALL capture the old msg value; the new value SHALL be used from the following tick.
REQ-026 Outside the window, or with video_on=0, direccion and rom SHALL still update per REQ-021, and text_pixel SHALL become 0.
REQ-027 At column 63 -> 64 the window SHALL close cleanly, with no read of msg beyond index 7.

Reset
REQ-028 While reset_n=0, regardless of clk: direccion=0, rom=0, bit_q=0, win_q=0, text_pixel=0, wr_ack=0.
REQ-029 On reset, msg SHALL load {1,2,3,4,5,6,0,0} (slots 0..7, "JVMBSL" followed by two spaces).
REQ-030 A reset asserted mid-frame SHALL abort the pipeline. After release, text_pixel SHALL be valid from the second pixel_tick.
REQ-031 A write coincident with reset assertion SHALL be discarded and SHALL produce no wr_ack.

Configuration
REQ-032 Macro FONT_READER_SCALE2_EN.
  - Defined: window is 128x32. dx and dy are each shifted right by 1 before REQ-020/021 slicing, so every glyph pixel appears 2x2.
  - Undefined: 64x16 window at 1:1 scale. Latency is unchanged in both builds.

Verification
REQ-033 Reset release, then scan pixel_x=288..295 at pixel_y=234 with video_on=1: direccion=1, rom=2; with the ROM returning 8'hFE, text_pixel SHALL read 1,1,1,1,1,1,1,0, delayed 2 ticks.
REQ-034 pixel_x=287 and pixel_x=352 at pixel_y=240: text_pixel=0 for both. pixel_x=0, pixel_y=0: text_pixel=0 with no wrap-in.
REQ-035 wr_en=1, wr_idx=6, wr_code=3, then scan slot 6: wr_ack pulses once, and direccion=3 for dx=48..55.
REQ-036 Write msg[0]=5 on the same edge that stage 1 reads slot 0: that tick gives direccion=1, the next tick gives direccion=5.
REQ-037 Hold pixel_tick=0 for 5 clks mid-glyph: text_pixel and direccion are unchanged. Assert reset_n=0 mid-window: outputs are 0 immediately and msg returns to {1,2,3,4,5,6,0,0}.
REQ-038 Scale-2 build, pixel_x=290, pixel_y=236: direccion=1, rom=2, bit_q=1.

Source files
------------

// File: rtl/font_reader.sv
`default_nettype none
// font_reader: two-stage pixel pipeline that maps a 64x16 text window onto an 8-glyph message register.
// Build macro FONT_READER_SCALE2_EN: 128x32 window with every glyph pixel doubled to 2x2.
module font_reader #(
    parameter logic [9:0] X0 = 10'd288,
    parameter logic [9:0] Y0 = 10'd232
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [2:0] wr_code,
    output logic       wr_ack,
    output logic [2:0] direccion,
    output logic [3:0] rom,
    input  logic [7:0] rom_data,
    output logic       text_pixel
);

`ifdef FONT_READER_SCALE2_EN
    localparam logic [9:0] WIN_W = 10'd128;
    localparam logic [9:0] WIN_H = 10'd32;
`else
    localparam logic [9:0] WIN_W = 10'd64;
    localparam logic [9:0] WIN_H = 10'd16;
`endif

    logic [10:0] dx_full, dy_full;
    logic [5:0]  sx;
    logic [3:0]  sy;
    logic        in_win;

    logic [2:0] msg_q [8];
    logic [2:0] msg_d [8];
    logic [2:0] dir_q, dir_d;
    logic [3:0] rom_q, rom_d;
    logic [2:0] bit_q, bit_d;
    logic       win_q, win_d;
    logic       pix_q, pix_d;
    logic       ack_q, ack_d;

    // Bit 10 is the borrow: pixels left of / above the window can never wrap into it.
    always_comb begin
        dx_full = {1'b0, pixel_x} - {1'b0, X0};
        dy_full = {1'b0, pixel_y} - {1'b0, Y0};
        in_win  = ~dx_full[10] & ~dy_full[10] &
                  (dx_full[9:0] < WIN_W) & (dy_full[9:0] < WIN_H);
`ifdef FONT_READER_SCALE2_EN
        sx = dx_full[6:1];
        sy = dy_full[4:1];
`else
        sx = dx_full[5:0];
        sy = dy_full[3:0];
`endif
    end

    always_comb begin
        msg_d = msg_q;
        if (wr_en) begin
            msg_d[wr_idx] = wr_code;
        end
        ack_d = wr_en;
        dir_d = dir_q;
        rom_d = rom_q;
        bit_d = bit_q;
        win_d = win_q;
        pix_d = pix_q;
        if (pixel_tick) begin
            // Stage 1 reads msg_q, so a same-edge write is only seen on the next tick.
            dir_d = msg_q[sx[5:3]];
            rom_d = sy;
            bit_d = sx[2:0];
            win_d = in_win & video_on;
            pix_d = win_q & rom_data[~bit_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_q[0] <= 3'd1;
            msg_q[1] <= 3'd2;
            msg_q[2] <= 3'd3;
            msg_q[3] <= 3'd4;
            msg_q[4] <= 3'd5;
            msg_q[5] <= 3'd6;
            msg_q[6] <= 3'd0;
            msg_q[7] <= 3'd0;
            dir_q    <= 3'd0;
            rom_q    <= 4'd0;
            bit_q    <= 3'd0;
            win_q    <= 1'b0;
            pix_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            msg_q <= msg_d;
            dir_q <= dir_d;
            rom_q <= rom_d;
            bit_q <= bit_d;
            win_q <= win_d;
            pix_q <= pix_d;
            ack_q <= ack_d;
        end
    end

    assign wr_ack     = ack_q;
    assign direccion  = dir_q;
    assign rom        = rom_q;
    assign text_pixel = pix_q;

endmodule
`default_nettype wire

// File: tb/tb_font_reader.sv
`default_nettype none
// tb_font_reader: table vectors and scoreboard-checked sequences for font_reader.
module tb_font_reader;
    localparam logic [9:0] X0 = 10'd288;
    localparam logic [9:0] Y0 = 10'd232;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pixel_tick = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_idx = '0;
    logic [2:0] wr_code = '0;
    logic       wr_ack;
    logic [2:0] direccion;
    logic [3:0] rom;
    logic [7:0] rom_data;
    logic       text_pixel;

    logic       rom_fixed = 1'b1;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [2:0] msg_m [8];
    logic       exp_q [$];
    logic [2:0] last_dir;
    logic [3:0] last_rom;
    logic       last_pix;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic [2:0] dir;
        logic [3:0] rom;
        logic       pix;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [2:0] d, input logic [3:0] r);
        return {d, r, d[0]} ^ 8'hA5;
    endfunction

    always_comb rom_data = rom_fixed ? 8'hFE : rom_fn(direccion, rom);

    font_reader #(.X0(X0), .Y0(Y0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_tick (pixel_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_code    (wr_code),
        .wr_ack     (wr_ack),
        .direccion  (direccion),
        .rom        (rom),
        .rom_data   (rom_data),
        .text_pixel (text_pixel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: expected stage-1 outputs and final pixel for one input pixel.
    task automatic model(input logic [9:0] x, input logic [9:0] y, input logic von,
                         output logic [2:0] d, output logic [3:0] r, output logic p);
        logic [9:0] dx, dy;
        logic [7:0] g;
        logic [2:0] b;
        int w, h, sh;
`ifdef FONT_READER_SCALE2_EN
        w = 128; h = 32; sh = 1;
`else
        w = 64;  h = 16; sh = 0;
`endif
        dx = (x - X0) >> sh;
        dy = (y - Y0) >> sh;
        d  = msg_m[dx[5:3]];
        r  = dy[3:0];
        b  = dx[2:0];
        g  = rom_fixed ? 8'hFE : rom_fn(d, r);
        p  = von && (x >= X0) && (int'(x) - int'(X0) < w) &&
             (y >= Y0) && (int'(y) - int'(Y0) < h) && g[7 - b];
    endtask

    task automatic step(input string name, input logic [9:0] x, input logic [9:0] y,
                        input logic von, input logic we, input logic [2:0] wi,
                        input logic [2:0] wc, input logic [2:0] ed, input logic [3:0] er,
                        input logic ep);
        pixel_x = x; pixel_y = y; video_on = von; pixel_tick = 1'b1;
        wr_en = we; wr_idx = wi; wr_code = wc;
        @(posedge clk); #1;
        pixel_tick = 1'b0; wr_en = 1'b0;
        if (we) msg_m[wi] = wc;
        exp_q.push_back(ep);
        check({name, " dir"}, direccion, ed);
        check({name, " rom"}, rom, er);
        check({name, " ack"}, wr_ack, we);
        last_dir = ed;
        last_rom = er;
        if (exp_q.size() > 1) begin
            last_pix = exp_q.pop_front();
            check({name, " pix"}, text_pixel, last_pix);
        end
    endtask

    task automatic mstep(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic von, input logic we, input logic [2:0] wi, input logic [2:0] wc);
        logic [2:0] d;
        logic [3:0] r;
        logic       p;
        model(x, y, von, d, r, p);
        step(name, x, y, von, we, wi, wc, d, r, p);
    endtask

    task automatic wr(input logic [2:0] wi, input logic [2:0] wc);
        wr_en = 1'b1; wr_idx = wi; wr_code = wc;
        @(posedge clk); #1;
        wr_en = 1'b0;
        msg_m[wi] = wc;
        check("wr ack", wr_ack, 1);
    endtask

    // Asserts reset between edges; optionally with a write request pending that must be dropped.
    task automatic do_reset(input logic we);
        wr_en = we; wr_idx = 3'd1; wr_code = 3'd7;
        #2 reset_n = 1'b0;
        #1;
        check("rst dir", direccion, 0);
        check("rst rom", rom, 0);
        check("rst pix", text_pixel, 0);
        check("rst ack", wr_ack, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst ack hold", wr_ack, 0);
        end
        wr_en = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) msg_m[i] = (i < 6) ? 3'(i + 1) : 3'd0;
        exp_q.delete();
        exp_q.push_back(1'b0);
    endtask

    initial begin
        do_reset(1'b0);

`ifdef FONT_READER_SCALE2_EN
        vecs.push_back('{10'd290, 10'd236, 1'b1, 3'd1, 4'd2,  1'b1});
        vecs.push_back('{10'd415, 10'd232, 1'b1, 3'd0, 4'd0,  1'b0});
        vecs.push_back('{10'd416, 10'd232, 1'b1, 3'd1, 4'd0,  1'b0});
        vecs.push_back('{10'd288, 10'd263, 1'b1, 3'd1, 4'd15, 1'b1});
        vecs.push_back('{10'd288, 10'd264, 1'b1, 3'd1, 4'd0,  1'b0});
`else
        for (int i = 0; i < 8; i++)
            vecs.push_back('{10'(288 + i), 10'd234, 1'b1, 3'd1, 4'd2, (i != 7)});
        vecs.push_back('{10'd287, 10'd240, 1'b1, 3'd0, 4'd8,  1'b0});
        vecs.push_back('{10'd352, 10'd240, 1'b1, 3'd1, 4'd8,  1'b0});
        vecs.push_back('{10'd0,   10'd0,   1'b1, 3'd5, 4'd8,  1'b0});
        vecs.push_back('{10'd290, 10'd234, 1'b0, 3'd1, 4'd2,  1'b0});
        vecs.push_back('{10'd350, 10'd234, 1'b1, 3'd0, 4'd2,  1'b1});
        vecs.push_back('{10'd351, 10'd234, 1'b1, 3'd0, 4'd2,  1'b0});
        vecs.push_back('{10'd352, 10'd234, 1'b1, 3'd1, 4'd2,  1'b0});
        vecs.push_back('{10'd288, 10'd247, 1'b1, 3'd1, 4'd15, 1'b1});
        vecs.push_back('{10'd288, 10'd248, 1'b1, 3'd1, 4'd0,  1'b0});
        vecs.push_back('{10'd288, 10'd231, 1'b1, 3'd1, 4'd15, 1'b0});
`endif
        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].von, 1'b0, 3'd0, 3'd0,
                 vecs[i].dir, vecs[i].rom, vecs[i].pix);

        // Back-to-back writes, then read slot 6 across its eight columns.
        wr(3'd6, 3'd3);
        wr(3'd2, 3'd4);
        @(posedge clk); #1;
        check("ack idle", wr_ack, 0);
        for (int i = 0; i < 8; i++)
            mstep("slot6", 10'(336 + i), 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);

        // Write to slot 0 on the same edge stage 1 reads it.
        mstep("same-edge", 10'd288, 10'd234, 1'b1, 1'b1, 3'd0, 3'd5);
        mstep("after-wr",  10'd288, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);

        // Pending pixel is video-off, so the ROM can change without affecting it.
        mstep("flush", 10'd0, 10'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        rom_fixed = 1'b0;
        for (int i = 0; i < 40; i++)
            mstep("rand", 10'($urandom_range(280, 360)), 10'($urandom_range(228, 252)),
                  ($urandom_range(0, 7) != 0), 1'b0, 3'd0, 3'd0);

        for (int i = 0; i < 5; i++) begin
            pixel_x = 10'(300 + i); pixel_y = 10'd240; video_on = 1'b1;
            @(posedge clk); #1;
            check("hold dir", direccion, last_dir);
            check("hold rom", rom, last_rom);
            check("hold pix", text_pixel, last_pix);
        end
        mstep("resume", 10'd305, 10'd238, 1'b1, 1'b0, 3'd0, 3'd0);
        mstep("resume", 10'd306, 10'd238, 1'b1, 1'b0, 3'd0, 3'd0);

        mstep("flush", 10'd0, 10'd0, 1'b0, 1'b0, 3'd0, 3'd0);
        rom_fixed = 1'b1;
        mstep("pre-rst", 10'd288, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);
        mstep("pre-rst", 10'd289, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);
        do_reset(1'b0);
        mstep("post-rst s0", 10'd288, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);
        mstep("post-rst s6", 10'd336, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);
        mstep("post-rst s2", 10'd304, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);

        do_reset(1'b1);
        @(posedge clk); #1;
        check("rst-wr ack", wr_ack, 0);
        mstep("rst-wr s1", 10'd296, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);
        mstep("rst-wr s1", 10'd297, 10'd234, 1'b1, 1'b0, 3'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
